// File: rtl/ad5791_pkg.sv
// rtl/ad5791_pkg.sv - AD5791 SPI frame field positions, register addresses and receiver FSM states.
package ad5791_pkg;

  localparam logic [2:0] ADDR_DAC     = 3'b001;
  localparam logic [2:0] ADDR_CTRL    = 3'b010;
  localparam logic [2:0] ADDR_CLRCODE = 3'b011;
  localparam logic [2:0] ADDR_SWCTRL  = 3'b100;

  localparam int RW_BIT   = 23;
  localparam int ADDR_MSB = 22;
  localparam int ADDR_LSB = 20;
  localparam int DATA_MSB = 19;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/pmd_sync_edge.sv
// rtl/pmd_sync_edge.sv - 2-FF synchronizer + history flop with rise/fall detect per bit.
// AD5791_RX_GLITCH_FILTER_EN adds a 2-cycle stability filter ahead of the edge detector.
module pmd_sync_edge #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         a_clk,
  input  logic         a_resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1, s2, hist;

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

`ifdef AD5791_RX_GLITCH_FILTER_EN
  logic [W-1:0] s3, filt;

  // A bit only takes the new level once two consecutive synced samples agree.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      s3   <= RST_VAL;
      filt <= RST_VAL;
    end else begin
      s3   <= s2;
      filt <= ((s2 ~^ s3) & s2) | ((s2 ^ s3) & filt);
    end
  end

  assign level = filt;
`else
  assign level = s2;
`endif

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      hist <= RST_VAL;
    end else begin
      hist <= level;
    end
  end

  assign rise = level & ~hist;
  assign fall = ~level & hist;

endmodule

// File: rtl/axis_ad5791_spi_rx.sv
// rtl/axis_ad5791_spi_rx.sv - AD5791 PMD SPI receiver: oversamples SCLK/SYNC/SDIN, emits DAC writes as AXIS words.
// Optional SCLK glitch rejection via AD5791_RX_GLITCH_FILTER_EN (see pmd_sync_edge).
module axis_ad5791_spi_rx
  import ad5791_pkg::*;
#(
  parameter int NUM_DAC           = 6,
  parameter int DAC_DATA_WIDTH    = 20,
  parameter int DAC_WORD_WIDTH    = 24,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int MAX_EXTRA_EDGES   = 1
) (
  input  logic                                 a_clk,
  input  logic                                 a_resetn,
  input  logic                                 wire_PMD_clk,
  input  logic                                 wire_PMD_sync,
  input  logic [NUM_DAC-1:0]                   wire_PMD_dac,
  output logic [NUM_DAC*MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [NUM_DAC-1:0]                   M_AXIS_tvalid,
  output logic [NUM_DAC*DAC_WORD_WIDTH-1:0]    last_word,
  output logic [31:0]                          frame_count,
  output logic [15:0]                          error_count,
  output logic                                 busy
);

  localparam int           W        = NUM_DAC + 2;
  localparam logic [W-1:0] PIN_RST  = {1'b1, 1'b0, {NUM_DAC{1'b0}}};
  localparam logic [4:0]   LEN_MIN  = 5'(DAC_WORD_WIDTH);
  localparam logic [4:0]   LEN_MAX  = 5'(DAC_WORD_WIDTH + MAX_EXTRA_EDGES);

  logic [W-1:0] pin_lvl, pin_rise, pin_fall;

  pmd_sync_edge #(
    .W       (W),
    .RST_VAL (PIN_RST)
  ) u_sync (
    .a_clk    (a_clk),
    .a_resetn (a_resetn),
    .d        ({wire_PMD_sync, wire_PMD_clk, wire_PMD_dac}),
    .level    (pin_lvl),
    .rise     (pin_rise),
    .fall     (pin_fall)
  );

  logic               sync_lvl, sync_rise, sync_fall, sclk_fall;
  logic [NUM_DAC-1:0] sdin;
  logic               unused_edges;

  assign sync_lvl     = pin_lvl[W-1];
  assign sync_rise    = pin_rise[W-1];
  assign sync_fall    = pin_fall[W-1];
  assign sclk_fall    = pin_fall[NUM_DAC];
  assign sdin         = pin_lvl[NUM_DAC-1:0];
  assign unused_edges = ^{pin_rise[W-2:0], pin_fall[NUM_DAC-1:0], pin_lvl[NUM_DAC]};

  rx_state_t                 state;
  logic [4:0]                bit_cnt;
  logic [DAC_WORD_WIDTH-1:0] sr [NUM_DAC];
  logic [2:0]                warm;
  logic                      armed;

  // The synchronizer resets to SYNC=1, so a pin already low at reset release would
  // look like a falling edge; frames are only accepted once SYNC was seen high for real.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      bit_cnt       <= '0;
      warm          <= '0;
      armed         <= 1'b0;
      frame_count   <= '0;
      error_count   <= '0;
      M_AXIS_tvalid <= '0;
      M_AXIS_tdata  <= '0;
      last_word     <= '0;
      for (int i = 0; i < NUM_DAC; i++) sr[i] <= '0;
    end else begin
      M_AXIS_tvalid <= '0;
      if (warm != 3'd7) warm <= warm + 3'd1;
      else if (sync_lvl) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          busy    <= 1'b0;
          if (sync_fall && armed) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
            for (int i = 0; i < NUM_DAC; i++) sr[i] <= '0;
          end
        end
        ST_SHIFT: begin
          if (sync_rise) begin
            state <= ST_DONE;
          end else if (sclk_fall) begin
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt < LEN_MIN) begin
              for (int i = 0; i < NUM_DAC; i++)
                sr[i] <= {sr[i][DAC_WORD_WIDTH-2:0], sdin[i]};
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (bit_cnt >= LEN_MIN && bit_cnt <= LEN_MAX) begin
            frame_count <= frame_count + 32'd1;
            for (int i = 0; i < NUM_DAC; i++) begin
              last_word[i*DAC_WORD_WIDTH +: DAC_WORD_WIDTH] <= sr[i];
              if (!sr[i][RW_BIT] && sr[i][ADDR_MSB:ADDR_LSB] == ADDR_DAC) begin
                M_AXIS_tdata[i*MAXIS_TDATA_WIDTH +: MAXIS_TDATA_WIDTH] <=
                  {sr[i][DATA_MSB:DATA_LSB], {(MAXIS_TDATA_WIDTH-DAC_DATA_WIDTH){1'b0}}};
                M_AXIS_tvalid[i] <= 1'b1;
              end
            end
          end else if (error_count != 16'hFFFF) begin
            error_count <= error_count + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
